mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// 32 shift-add (multiply) or restoring (divide) iterations per operation, sign fixed up at the end.
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Flush,
    input  logic        WriteHi,
    input  logic        WriteLo,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] wk_hi_q, wk_hi_d;
    logic [31:0] wk_lo_q, wk_lo_d;
    logic [31:0] mcand_q, mcand_d;
    logic        is_div_q, is_div_d;
    logic        neg_hi_q, neg_hi_d;
    logic        neg_lo_q, neg_lo_d;
    logic        bzero_q, bzero_d;

    // Operand magnitudes; 0x80000000 negates to itself, read as unsigned 2^31.
    logic        signed_op, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    assign signed_op = ~Op[0];
    assign sign_a    = signed_op & SrcA[31];
    assign sign_b    = signed_op & SrcB[31];
    assign mag_a     = sign_a ? (32'd0 - SrcA) : SrcA;
    assign mag_b     = sign_b ? (32'd0 - SrcB) : SrcB;

    // One iteration of either algorithm.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;
    assign mul_sum   = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign div_shift = {wk_hi_q, wk_lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    always_comb begin
        if (is_div_q) begin
            step_hi = div_ge ? (div_shift[31:0] - mcand_q) : div_shift[31:0];
            step_lo = {wk_lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], wk_lo_q[31:1]};
        end
    end

    // Final sign correction applied on the last iteration.
    logic [63:0] prod, prod_fix;
    logic [31:0] res_hi, res_lo;
    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_lo_q ? (64'd0 - prod) : prod;
    always_comb begin
        if (is_div_q) begin
            res_hi = neg_hi_q ? (32'd0 - step_hi) : step_hi;
            res_lo = bzero_q ? 32'hFFFF_FFFF : (neg_lo_q ? (32'd0 - step_lo) : step_lo);
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        wk_hi_d  = wk_hi_q;
        wk_lo_d  = wk_lo_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        bzero_d  = bzero_q;
        case (state_q)
            S_IDLE: begin
                if (WriteHi) hi_d = WriteData;
                if (WriteLo) lo_d = WriteData;
                if (Start && !Flush) begin
                    state_d  = S_CALC;
                    busy_d   = 1'b1;
                    cnt_d    = 6'd0;
                    is_div_d = Op[1];
                    wk_hi_d  = 32'd0;
                    wk_lo_d  = Op[1] ? mag_a : mag_b;
                    mcand_d  = Op[1] ? mag_b : mag_a;
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = Op[1] ? sign_a : (sign_a ^ sign_b);
                    bzero_d  = (SrcB == 32'd0);
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    wk_hi_d = step_hi;
                    wk_lo_d = step_lo;
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (WriteHi) hi_d = WriteData;
                if (WriteLo) lo_d = WriteData;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            wk_hi_q  <= 32'd0;
            wk_lo_q  <= 32'd0;
            mcand_q  <= 32'd0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wk_hi_q  <= wk_hi_d;
            wk_lo_q  <= wk_lo_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            bzero_q  <= bzero_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        Clk, Rst_n, Start, Flush, WriteHi, WriteLo;
    logic [1:0]  Op;
    logic [31:0] SrcA, SrcB, WriteData;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;
    int          tests, fails;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mult_div_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Flush(Flush), .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called 1ns after E0: counts Busy cycles, then checks the Done cycle and the cycle after.
    task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input logic dflush);
        int n, early_done;
        n = 0;
        early_done = 0;
        while (Busy && n < 40) begin
            if (Done) early_done++;
            n++;
            @(posedge Clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_early_done"}, 64'(early_done), 64'd0);
        chk({tag, "_done"}, {63'd0, Done}, 64'd1);
        chk({tag, "_hilo"}, {Hi, Lo}, {eh, el});
        Flush = dflush;
        @(posedge Clk); #1;
        Flush = 1'b0;
        chk({tag, "_done_clear"}, {62'd0, Done, Busy}, 64'd0);
        chk({tag, "_hilo_hold"}, {Hi, Lo}, {eh, el});
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        @(negedge Clk);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        finish_op(tag, eh, el, 1'b0);
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        Rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        Op = 2'b00; SrcA = 32'd0; SrcB = 32'd0; WriteData = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", {Busy, Done, Hi, Lo}, 66'd0);

        // Start presented on the very first edge after reset release.
        @(negedge Clk);
        Rst_n = 1'b1; Start = 1'b1; Op = OP_MULTU; SrcA = 32'd6; SrcB = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        finish_op("first_edge_start", 32'd0, 32'd42, 1'b0);

        run_op("mult_m1x2",    OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x5",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_min_m1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_100_0",   OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_m5_0",     OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Flush during DONE must not disturb committed results.
        @(negedge Clk);
        Start = 1'b1; Op = OP_DIVU; SrcA = 32'd50; SrcB = 32'd8;
        @(posedge Clk); #1;
        Start = 1'b0;
        finish_op("flush_in_done", 32'd2, 32'd6, 1'b1);

        // MTHI/MTLO in IDLE.
        @(negedge Clk);
        WriteHi = 1'b1; WriteLo = 1'b0; WriteData = 32'h11;
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h22;
        @(negedge Clk);
        WriteLo = 1'b0;
        chk("mthi_mtlo_idle", {Hi, Lo}, {32'h11, 32'h22});

        // DIVU flushed mid-CALC; a write during CALC is also ignored.
        @(negedge Clk);
        Start = 1'b1; Op = OP_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        WriteHi = 1'b1; WriteData = 32'h99;
        @(posedge Clk); #1;
        WriteHi = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("calc_busy_before_flush", {63'd0, Busy}, 64'd1);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        chk("flush_busy_drop", {63'd0, Busy}, 64'd0);
        n = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done || Busy) n++;
        end
        chk("flush_no_done", 64'(n), 64'd0);
        chk("flush_hilo_kept", {Hi, Lo}, {32'h11, 32'h22});

        // Flush and Start together in IDLE: Start ignored.
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; Op = OP_MULTU; SrcA = 32'd3; SrcB = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        chk("flush_start_idle", {62'd0, Busy, Done}, 64'd0);
        repeat (35) @(posedge Clk);
        #1;
        chk("flush_start_hilo", {Hi, Lo}, {32'h11, 32'h22});

        // Write with an accepted Start lands at E0 and is overwritten at E32.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULTU; SrcA = 32'd3; SrcB = 32'd4;
        WriteHi = 1'b1; WriteData = 32'hAB;
        @(posedge Clk); #1;
        Start = 1'b0; WriteHi = 1'b0;
        chk("write_at_e0", {Hi, Lo}, {32'hAB, 32'h22});
        finish_op("write_then_result", 32'd0, 32'd12, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_reset", {Busy, Done, Hi, Lo}, 66'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done || Busy) n++;
        end
        chk("reset_no_done", 64'(n), 64'd0);
        run_op("after_reset", OP_MULT, 32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFAF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
